// File: rtl/min_max_pkg.sv
// Shared definitions for the min/max finder and its array loader front end.
//
// Contents
//   DefDepth, DefWidth : default array geometry (DEPTH entries of WIDTH bits)
//   DefTimeout         : default WAIT budget in clocks, also used by the finder benches
//   TmoW               : width of the WAIT timeout counter
//   state_e            : one-hot, 5-bit state encoding (INI, LOAD, STRT, WAIT, DONE)
package min_max_pkg;

  localparam int unsigned DefDepth   = 16;
  localparam int unsigned DefWidth   = 8;
  localparam int unsigned DefTimeout = 255;
  localparam int unsigned TmoW       = 8;
  localparam int unsigned NumStates  = 5;

  // One-hot so each Q* output is a single state bit.
  typedef enum logic [NumStates-1:0] {
    StIni  = 5'b00001,
    StLoad = 5'b00010,
    StStrt = 5'b00100,
    StWait = 5'b01000,
    StDone = 5'b10000
  } state_e;

endpackage

// File: rtl/min_max_array_ram.sv
// DEPTH x WIDTH storage array for the min/max loader.
//
// One synchronous write port and one asynchronous (combinational) read port, so the finder
// can index the array at any time, in any loader state. Contents are never reset.
//
// Ports
//   clk     : rising-edge clock for the write port
//   we      : write enable
//   wr_addr : write index
//   wr_data : write data
//   rd_addr : read index
//   rd_data : mem[rd_addr], combinational
module min_max_array_ram
  import min_max_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned WIDTH = DefWidth,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/min_max_array_loader.sv
// Initiator side of the min/max finder handshake.
//
// Collects DEPTH bytes from a valid/ready stream into an array, pulses Fnd_start for one
// clock, serves the finder's reads through Rd_addr/Rd_data, waits (bounded by TIMEOUT) for
// Fnd_done, then presents Max/Min on Res_* until Res_ack.
//
// Optional build macro
//   MIN_MAX_SELF_CHECK_EN : tracks a running max/min of the loaded bytes and raises Mismatch
//                           at capture if the finder's answer disagrees.
//
// Ports
//   Clk, Reset_n          : clock, synchronous active-low reset
//   Din/Din_valid/Din_ready : byte stream in; accepted in INI and LOAD only
//   Rd_addr/Rd_data       : finder read port, combinational, valid in every state
//   Fnd_start             : one-clock start pulse to the finder
//   Fnd_done/Fnd_max/Fnd_min : finder completion and results
//   Res_max/Res_min/Err   : captured results and timeout flag
//   Res_valid/Res_ack     : result handshake; Res_valid is high throughout DONE
//   Qi,Ql,Qs,Qw,Qd        : one-hot state (INI, LOAD, STRT, WAIT, DONE)
//   Mismatch              : self-check result (only with MIN_MAX_SELF_CHECK_EN)
module min_max_array_loader
  import min_max_pkg::*;
#(
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned TIMEOUT = DefTimeout,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Din,
  input  logic             Din_valid,
  output logic             Din_ready,
  input  logic [AW-1:0]    Rd_addr,
  output logic [WIDTH-1:0] Rd_data,
  output logic             Fnd_start,
  input  logic             Fnd_done,
  input  logic [WIDTH-1:0] Fnd_max,
  input  logic [WIDTH-1:0] Fnd_min,
  output logic [WIDTH-1:0] Res_max,
  output logic [WIDTH-1:0] Res_min,
  output logic             Res_valid,
  input  logic             Res_ack,
  output logic             Err,
  output logic             Qi,
  output logic             Ql,
  output logic             Qs,
  output logic             Qw,
  output logic             Qd
`ifdef MIN_MAX_SELF_CHECK_EN
  ,
  output logic             Mismatch
`endif
);

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic             armed_q, armed_d;
  logic [WIDTH-1:0] res_max_q, res_max_d;
  logic [WIDTH-1:0] res_min_q, res_min_d;
  logic             err_q, err_d;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic             capture;
  logic             tmo_hit;
  logic             leave_done;

  // Storage
  min_max_array_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk     (Clk),
    .we      (wr_en),
    .wr_addr (wr_addr),
    .wr_data (Din),
    .rd_addr (Rd_addr),
    .rd_data (Rd_data)
  );

  // Streaming input is open only while filling the array.
  assign Din_ready = (state_q == StIni) || (state_q == StLoad);
  assign wr_en     = Din_valid && Din_ready;
  // INI always writes entry 0, independent of where the pointer was left.
  assign wr_addr   = (state_q == StIni) ? '0 : wr_ptr_q;

  // A finder still showing Done from a previous run is ignored until Done has been seen low.
  assign capture    = (state_q == StWait) && armed_q && Fnd_done;
  assign tmo_hit    = (tmo_cnt_q == TmoW'(TIMEOUT));
  assign leave_done = (state_q == StDone) && Res_ack;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    tmo_cnt_d = tmo_cnt_q;
    armed_d   = armed_q;
    res_max_d = res_max_q;
    res_min_d = res_min_q;
    err_d     = err_q;

    unique case (state_q)
      StIni: begin
        if (Din_valid) begin
          wr_ptr_d = AW'(1);
          state_d  = StLoad;
        end
      end
      StLoad: begin
        if (Din_valid) begin
          // Pointer wraps to 0 on the last entry since DEPTH is a power of two.
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (wr_ptr_q == AW'(DEPTH - 1)) begin
            state_d = StStrt;
          end
        end
      end
      StStrt: begin
        tmo_cnt_d = '0;
        armed_d   = 1'b0;
        state_d   = StWait;
      end
      StWait: begin
        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        if (!Fnd_done) begin
          armed_d = 1'b1;
        end
        // Completion takes priority over a coincident timeout.
        if (capture) begin
          res_max_d = Fnd_max;
          res_min_d = Fnd_min;
          err_d     = 1'b0;
          state_d   = StDone;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (Res_ack) begin
          state_d = StIni;
        end
      end
      default: begin
        state_d = StIni;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= StIni;
      wr_ptr_q  <= '0;
      tmo_cnt_q <= '0;
      armed_q   <= 1'b0;
      res_max_q <= '0;
      res_min_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      tmo_cnt_q <= tmo_cnt_d;
      armed_q   <= armed_d;
      res_max_q <= res_max_d;
      res_min_q <= res_min_d;
      err_q     <= err_d;
    end
  end

  assign Fnd_start = (state_q == StStrt);
  assign Res_valid = (state_q == StDone);
  assign Res_max   = res_max_q;
  assign Res_min   = res_min_q;
  assign Err       = err_q;

  assign Qi = (state_q == StIni);
  assign Ql = (state_q == StLoad);
  assign Qs = (state_q == StStrt);
  assign Qw = (state_q == StWait);
  assign Qd = (state_q == StDone);

`ifdef MIN_MAX_SELF_CHECK_EN
  logic [WIDTH-1:0] loc_max_q, loc_max_d;
  logic [WIDTH-1:0] loc_min_q, loc_min_d;
  logic             mismatch_q, mismatch_d;

  always_comb begin
    loc_max_d  = loc_max_q;
    loc_min_d  = loc_min_q;
    mismatch_d = mismatch_q;
    if (wr_en) begin
      if (state_q == StIni) begin
        // First byte seeds both extremes.
        loc_max_d = Din;
        loc_min_d = Din;
      end else begin
        if (Din > loc_max_q) loc_max_d = Din;
        if (Din < loc_min_q) loc_min_d = Din;
      end
    end
    if (capture) begin
      mismatch_d = (Fnd_max != loc_max_q) || (Fnd_min != loc_min_q);
    end else if (leave_done) begin
      mismatch_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      loc_max_q  <= '0;
      loc_min_q  <= '0;
      mismatch_q <= 1'b0;
    end else begin
      loc_max_q  <= loc_max_d;
      loc_min_q  <= loc_min_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign Mismatch = mismatch_q;
`else
  logic unused_leave_done;
  assign unused_leave_done = leave_done;
`endif

endmodule

// File: tb/tb_min_max_array_loader.sv
// Directed bench for min_max_array_loader: table of load/finder scenarios plus hand-written
// sequences for mid-load reset and a long DONE hold.
module tb_min_max_array_loader;
  import min_max_pkg::*;

  localparam int Timeout  = 255;
  localparam int MNormal  = 0;
  localparam int MNever   = 1;
  localparam int MSticky  = 2;
  localparam int MCorrupt = 3;

  logic       Clk_tb;
  logic       Reset_n;
  logic [7:0] Din;
  logic       Din_valid;
  logic       Din_ready;
  logic [3:0] Rd_addr;
  logic [7:0] Rd_data;
  logic       Fnd_start;
  logic       Fnd_done;
  logic [7:0] Fnd_max;
  logic [7:0] Fnd_min;
  logic [7:0] Res_max;
  logic [7:0] Res_min;
  logic       Res_valid;
  logic       Res_ack;
  logic       Err;
  logic       Qi, Ql, Qs, Qw, Qd;
`ifdef MIN_MAX_SELF_CHECK_EN
  logic       Mismatch;
`endif

  min_max_array_loader #(
    .DEPTH   (16),
    .WIDTH   (8),
    .TIMEOUT (Timeout)
  ) dut (
    .Clk       (Clk_tb),
    .Reset_n   (Reset_n),
    .Din       (Din),
    .Din_valid (Din_valid),
    .Din_ready (Din_ready),
    .Rd_addr   (Rd_addr),
    .Rd_data   (Rd_data),
    .Fnd_start (Fnd_start),
    .Fnd_done  (Fnd_done),
    .Fnd_max   (Fnd_max),
    .Fnd_min   (Fnd_min),
    .Res_max   (Res_max),
    .Res_min   (Res_min),
    .Res_valid (Res_valid),
    .Res_ack   (Res_ack),
    .Err       (Err),
    .Qi        (Qi),
    .Ql        (Ql),
    .Qs        (Qs),
    .Qw        (Qw),
    .Qd        (Qd)
`ifdef MIN_MAX_SELF_CHECK_EN
    ,
    .Mismatch  (Mismatch)
`endif
  );

  initial Clk_tb = 1'b0;
  always #5 Clk_tb = ~Clk_tb;

  int n_checks = 0;
  int n_pass   = 0;

  // Running totals; scenarios take snapshots and compare differences.
  int start_total = 0;
  int wait_total  = 0;
  always @(posedge Clk_tb) begin
    if (Fnd_start) start_total <= start_total + 1;
    if (Qw)        wait_total  <= wait_total + 1;
  end

  typedef struct {
    int         pat;
    bit         gaps;
    int         mode;
    bit         hold;
    logic [7:0] exp_max;
    logic [7:0] exp_min;
    logic       exp_err;
    logic       exp_mis;
  } vec_t;

  logic [7:0] pat [2][16];
  vec_t       vecs [4];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b, expected %0b", name, act, exp);
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h, expected %02h", name, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    Reset_n   = 1'b0;
    Din_valid = 1'b0;
    Res_ack   = 1'b0;
    Fnd_done  = 1'b0;
    @(negedge Clk_tb);
    @(negedge Clk_tb);
    Reset_n = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    chk1({tag, "_qi"}, Qi, 1'b1);
    chk1({tag, "_res_valid"}, Res_valid, 1'b0);
    chk1({tag, "_err"}, Err, 1'b0);
    chk8({tag, "_res_max"}, Res_max, 8'h00);
    chk8({tag, "_res_min"}, Res_min, 8'h00);
    chk1({tag, "_fnd_start"}, Fnd_start, 1'b0);
    chk1({tag, "_din_ready"}, Din_ready, 1'b1);
  endtask

  task automatic run_case(input vec_t v);
    int         s0;
    int         w0;
    int         n;
    logic [7:0] fmax;
    logic [7:0] fmin;

    s0 = start_total;
    if (v.mode == MSticky) begin
      // Finder still in a previous DONE, showing stale results.
      Fnd_done = 1'b1;
      Fnd_max  = 8'h11;
      Fnd_min  = 8'h22;
    end else begin
      Fnd_done = 1'b0;
      Fnd_max  = 8'h5A;
      Fnd_min  = 8'hA5;
    end
    chk1("ini_state", Qi, 1'b1);

    for (int k = 0; k < 16; k++) begin
      Din       = pat[v.pat][k];
      Din_valid = 1'b1;
      @(negedge Clk_tb);
      if (k == 0) chk1("load_state", Ql, 1'b1);
      if (v.gaps && (k == 4 || k == 10)) begin
        Din_valid = 1'b0;
        repeat (3) @(negedge Clk_tb);
        chk1("gap_hold", Ql, 1'b1);
      end
    end
    Din_valid = 1'b0;
    chk1("start_pulse", Fnd_start, 1'b1);
    chk1("strt_state", Qs, 1'b1);
    chk1("strt_not_ready", Din_ready, 1'b0);
    w0 = wait_total;

    @(negedge Clk_tb);
    chk1("wait_state", Qw, 1'b1);
    chk1("start_one_clock", Fnd_start, 1'b0);
    if (v.mode == MSticky) begin
      @(negedge Clk_tb);
      chk1("no_early_capture", Qw, 1'b1);
      Fnd_done = 1'b0;
    end

    // Finder model: scan the array through the read port.
    fmax = 8'h00;
    fmin = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      Rd_addr = 4'(i);
      #1;
      chk8("array_entry", Rd_data, pat[v.pat][i]);
      if (Rd_data > fmax) fmax = Rd_data;
      if (Rd_data < fmin) fmin = Rd_data;
      @(negedge Clk_tb);
    end

    if (v.mode != MNever) begin
      Fnd_max  = (v.mode == MCorrupt) ? (fmax ^ 8'h01) : fmax;
      Fnd_min  = fmin;
      Fnd_done = 1'b1;
      @(negedge Clk_tb);
      chk1("res_latency", Res_valid, 1'b1);
    end
    n = 0;
    while (!Res_valid && n < 400) begin
      @(negedge Clk_tb);
      n++;
    end
    if (!Res_valid) begin
      chk1("res_valid_bound", Res_valid, 1'b1);
      do_reset();
      return;
    end
    Fnd_done = 1'b0;

    if (v.mode == MNever) chki("tmo_wait_clks", wait_total - w0, Timeout + 1);
    chk8("res_max", Res_max, v.exp_max);
    chk8("res_min", Res_min, v.exp_min);
    chk1("err", Err, v.exp_err);
    chk1("done_state", Qd, 1'b1);
    chki("start_count", start_total - s0, 1);
`ifdef MIN_MAX_SELF_CHECK_EN
    chk1("mismatch", Mismatch, v.exp_mis);
`endif

    if (v.hold) begin
      Din       = 8'hAA;
      Din_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge Clk_tb);
        chk1("hold_not_ready", Din_ready, 1'b0);
        chk1("hold_valid", Res_valid, 1'b1);
      end
      chk8("hold_res_max", Res_max, v.exp_max);
      chk8("hold_res_min", Res_min, v.exp_min);
      Din_valid = 1'b0;
    end

    Res_ack = 1'b1;
    @(negedge Clk_tb);
    Res_ack = 1'b0;
    chk1("ack_to_ini", Qi, 1'b1);
    chk1("ack_valid_low", Res_valid, 1'b0);
`ifdef MIN_MAX_SELF_CHECK_EN
    chk1("mismatch_cleared", Mismatch, 1'b0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v5;
    vec_t vc;

    pat[0] = '{8'h3B, 8'h9A, 8'h64, 8'hF4, 8'h90, 8'h83, 8'h23, 8'hF4,
               8'hF4, 8'h85, 8'h02, 8'h99, 8'h02, 8'h02, 8'h84, 8'hF5};
    for (int i = 0; i < 16; i++) pat[1][i] = 8'h80;

    //          pat gaps mode      hold max    min    err   mis
    vecs[0] = '{0,  1'b0, MNormal, 1'b0, 8'hF5, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{0,  1'b1, MNormal, 1'b0, 8'hF5, 8'h02, 1'b0, 1'b0};
    vecs[2] = '{0,  1'b0, MNever,  1'b0, 8'hF5, 8'h02, 1'b1, 1'b0};
    vecs[3] = '{0,  1'b0, MSticky, 1'b0, 8'hF5, 8'h02, 1'b0, 1'b0};

    Din       = 8'h00;
    Din_valid = 1'b0;
    Rd_addr   = 4'h0;
    Fnd_done  = 1'b0;
    Fnd_max   = 8'h00;
    Fnd_min   = 8'h00;
    Res_ack   = 1'b0;
    Reset_n   = 1'b0;
    @(negedge Clk_tb);
    do_reset();
    check_reset_state("reset");

    for (int t = 0; t < 4; t++) run_case(vecs[t]);

    // Reset in the middle of a load, then a clean load of constant data.
    for (int k = 0; k < 7; k++) begin
      Din       = pat[0][k];
      Din_valid = 1'b1;
      @(negedge Clk_tb);
    end
    chk1("midload_state", Ql, 1'b1);
    do_reset();
    check_reset_state("midload_reset");

    v5 = '{1, 1'b0, MNormal, 1'b1, 8'h80, 8'h80, 1'b0, 1'b0};
    run_case(v5);

`ifdef MIN_MAX_SELF_CHECK_EN
    vc = '{0, 1'b0, MCorrupt, 1'b0, 8'hF4, 8'h02, 1'b0, 1'b1};
    run_case(vc);
`else
    vc = v5;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
